// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 fetch stage.
// Contents: fetch FSM state enum, instruction width, PC increment, default
// halt encoding. No logic.
package legv8_pkg;

  localparam int INSN_W = 32;
  localparam int PC_INC = 4;
  localparam logic [INSN_W-1:0] HALT_INSN_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/legv8_next_pc_mux.sv
// Next-PC priority mux with the sequential +4 incrementer.
// Latency: purely combinational, zero cycles.
// Backpressure: stall holds the PC; redirect overrides stall; hold (BOOT/HALT/halt hit) overrides all.
// Ports: state, halt_hit, redirect, redirect_pc, stall, pc_q in; next_pc out.
module legv8_next_pc_mux
  import legv8_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  fetch_state_t    state,
  input  logic            halt_hit,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  input  logic [PC_W-1:0] pc_q,
  output logic [PC_W-1:0] next_pc
);

  // Branch targets are word aligned; the low two bits are dropped.
  logic unused_rpc_bits;
  assign unused_rpc_bits = ^redirect_pc[1:0];

  always_comb begin
    next_pc = pc_q + PC_W'(PC_INC);
    // The halt word freezes at its own PC so memory keeps presenting it.
    if (state != RUN || halt_hit) begin
      next_pc = pc_q;
    end else if (redirect) begin
      next_pc = {redirect_pc[PC_W-1:2], 2'b00};
    end else if (stall) begin
      next_pc = pc_q;
    end
  end

endmodule

// File: rtl/legv8_fetch_unit.sv
// LEGv8 fetch stage: owns the PC, drives the synchronous imem, aligns instr/pc/valid at IF/ID.
// Latency: one cycle from imem_addr to out_instr/out_pc; redirect takes effect with zero bubbles.
// Backpressure: stall holds pc_q and re-reads the same word, so outputs stay stable while stalled.
// Ports: clk, rst_n; imem_addr/imem_instruction to memory; stall, redirect, redirect_pc from
//        hazard/branch logic; out_instr, out_pc, out_valid, halted, fetch_count to decode.
module legv8_fetch_unit
  import legv8_pkg::*;
#(
  parameter int                PC_W      = 64,
  parameter logic [PC_W-1:0]   RESET_PC  = 64'h0,
  parameter logic [INSN_W-1:0] HALT_INSN = HALT_INSN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       imem_addr,
  input  logic [INSN_W-1:0] imem_instruction,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [INSN_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_valid,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_t    state, state_nx;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;
  logic            accept;
  logic            halt_hit;

  // pc_q and the memory output register both load from next_pc on the same
  // edge, so out_instr is always the word at out_pc without any skid buffer.
  assign out_instr = imem_instruction;
  assign out_pc    = pc_q;
  assign out_valid = (state == RUN);
  assign halted    = (state == HALT);

  assign accept   = (state == RUN) && !stall && !redirect;
  assign halt_hit = accept && (imem_instruction == HALT_INSN);

  legv8_next_pc_mux #(
    .PC_W (PC_W)
  ) u_next_pc_mux (
    .state       (state),
    .halt_hit    (halt_hit),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .pc_q        (pc_q),
    .next_pc     (next_pc)
  );

  // Word index; memory truncates further to its own depth.
  assign imem_addr = next_pc[33:2];

  logic unused_next_pc;
  assign unused_next_pc = ^{next_pc[PC_W-1:34], next_pc[1:0]};

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = RUN;
      RUN:     if (halt_hit) state_nx = HALT;
      HALT:    state_nx = HALT;
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_q        <= RESET_PC;
      fetch_count <= 32'd0;
    end else begin
      state <= state_nx;
      pc_q  <= next_pc;
      // Halt word counts as accepted; redirect-cycle (wrong-path) word does not.
      if (accept) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Directed bench for legv8_fetch_unit with an imem model and expectation queue.
module tb_legv8_fetch_unit;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] cnt;
    logic        halted;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:255];
  exp_t        sbq [$];
  int          n_cmp;
  int          n_bad;

  legv8_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .out_valid        (out_valid),
    .halted           (halted),
    .fetch_count      (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory, one cycle latency, no enable.
  always @(posedge clk) imem_instruction <= mem[imem_addr[7:0]];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Called on a negedge: drive inputs for this cycle, check imem_addr, queue the
  // expected outputs for the following cycle, then clock and compare them.
  task automatic step(input logic st, input logic rd, input logic [63:0] rpc,
                      input logic [31:0] e_addr, input logic e_valid,
                      input logic [63:0] e_pc, input logic [31:0] e_cnt,
                      input logic e_halt);
    exp_t e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    chk("imem_addr", {32'd0, imem_addr}, {32'd0, e_addr});
    e.valid  = e_valid;
    e.pc     = e_pc;
    e.cnt    = e_cnt;
    e.halted = e_halt;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sbq.size() == 0) begin
      chk("queue_empty", 64'd1, 64'd0);
    end else begin
      e = sbq.pop_front();
      chk("out_valid",   {63'd0, out_valid},   {63'd0, e.valid});
      chk("out_pc",      out_pc,               e.pc);
      chk("fetch_count", {32'd0, fetch_count}, {32'd0, e.cnt});
      chk("halted",      {63'd0, halted},      {63'd0, e.halted});
      if (e.valid) chk("out_instr", {32'd0, out_instr}, {32'd0, mem[e.pc[9:2]]});
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid},   64'd0);
    chk({tag, "_halt"},  {63'd0, halted},      64'd0);
    chk({tag, "_cnt"},   {32'd0, fetch_count}, 64'd0);
    chk({tag, "_pc"},    out_pc,               64'd0);
    chk({tag, "_addr"},  {32'd0, imem_addr},   64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[5] = 32'hFFFF_FFFF;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'd0;
    repeat (3) @(negedge clk);
    #1 chk_reset_state("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_reset_state("boot");

    // BOOT then sequential fetch 0,4,8,12
    step(0, 0, 64'h0,  0, 1, 64'h00, 0, 0);
    step(0, 0, 64'h0,  1, 1, 64'h04, 1, 0);
    step(0, 0, 64'h0,  2, 1, 64'h08, 2, 0);
    step(0, 0, 64'h0,  3, 1, 64'h0C, 3, 0);
    // back to 8, then stall three cycles there
    step(0, 1, 64'h08, 2, 1, 64'h08, 3, 0);
    step(1, 0, 64'h0,  2, 1, 64'h08, 3, 0);
    step(1, 0, 64'h0,  2, 1, 64'h08, 3, 0);
    step(1, 0, 64'h0,  2, 1, 64'h08, 3, 0);
    step(0, 0, 64'h0,  3, 1, 64'h0C, 4, 0);
    // to pc 4, then unaligned redirect 0x1B -> 0x18
    step(0, 1, 64'h04, 1, 1, 64'h04, 4, 0);
    step(0, 1, 64'h1B, 6, 1, 64'h18, 4, 0);
    // to pc 8, then redirect+stall to 0x28 (redirect wins)
    step(0, 1, 64'h08, 2, 1, 64'h08, 4, 0);
    step(1, 1, 64'h28, 10, 1, 64'h28, 4, 0);
    step(0, 0, 64'h0, 11, 1, 64'h2C, 5, 0);
    step(0, 1, 64'h10, 4, 1, 64'h10, 5, 0);

    // asynchronous reset pulse at out_pc=16, no clock edge involved
    rst_n = 1'b0;
    #1 chk_reset_state("async_rst");
    #1 rst_n = 1'b1;

    // BOOT ignores redirect; then run sequentially into the halt word at 20
    step(0, 1, 64'h80, 0, 1, 64'h00, 0, 0);
    step(0, 0, 64'h0,  1, 1, 64'h04, 1, 0);
    step(0, 0, 64'h0,  2, 1, 64'h08, 2, 0);
    step(0, 0, 64'h0,  3, 1, 64'h0C, 3, 0);
    step(0, 0, 64'h0,  4, 1, 64'h10, 4, 0);
    step(0, 0, 64'h0,  5, 1, 64'h14, 5, 0);
    step(0, 0, 64'h0,  5, 0, 64'h14, 6, 1);
    // HALT ignores redirect and stall
    step(0, 1, 64'h40, 5, 0, 64'h14, 6, 1);
    step(1, 0, 64'h0,  5, 0, 64'h14, 6, 1);
    step(0, 0, 64'h0,  5, 0, 64'h14, 6, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/legv8_fetch_unit.md
Name: legv8_fetch_unit

Overview:
- Fetch stage for the LEGv8 single-issue core. It owns the program counter and drives the word address of the synchronous-read instruction memory, which has 1-cycle read latency and no enable.
- It aligns each returned instruction with its PC and a valid flag, forming the IF/ID boundary.
- It handles decode stall, branch redirect and a halt instruction.
- It sits between the branch/hazard logic (control inputs) and the decoder (consumer).

Parameters:
- PC_W, 64, program-counter width in bits (byte address).
- RESET_PC, 64'h0, byte address fetched first after reset.
- HALT_INSN, 32'hFFFF_FFFF, encoding that stops fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  32  word index to instruction memory; combinational = next_pc[33:2].
- imem_instruction  input  32  registered memory output for the word index presented on the previous edge.
- stall  input  1  decode cannot accept; hold current output.
- redirect  input  1  taken branch / jump.
- redirect_pc  input  PC_W  branch target byte address; bits [1:0] ignored and forced 0.
- out_instr  output  32  instruction to decode; combinational pass-through of imem_instruction.
- out_pc  output  PC_W  byte PC of out_instr (register pc_q).
- out_valid  output  1  out_instr/out_pc are meaningful.
- halted  output  1  halt instruction reached.
- fetch_count  output  32  instructions accepted by decode.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - rst_n low forces: state=BOOT, pc_q=RESET_PC, out_valid=0, halted=0, fetch_count=0.
- Alignment invariant: pc_q and the memory's output register update on the same edge from the same next_pc. out_instr is therefore always the word at out_pc. No skid buffer is needed.
- next_pc mux, in priority order:
  - state BOOT or HALT: pc_q.
  - redirect: {redirect_pc[PC_W-1:2],2'b00}.
  - stall: pc_q.
  - otherwise: pc_q+4, wrapping modulo 2^PC_W.
- imem_addr = next_pc[33:2] (word index, not byte address). The memory's own index truncation gives wrap-around within the memory.
- States:
  - BOOT: out_valid=0. The memory is reading RESET_PC. The first edge with rst_n high moves to RUN. Stall and redirect are ignored in BOOT.
  - RUN: out_valid=1, pc_q<=next_pc each edge.
    - If out_valid && out_instr==HALT_INSN && !stall && !redirect, go to HALT on that edge.
    - The halt word itself counts as accepted.
  - HALT: out_valid=0, halted=1, pc_q holds (next_pc=pc_q). Exit only via reset. redirect and stall are ignored.
- Redirect:
  - Zero-bubble redirect: on the next cycle out_pc=target and out_instr=mem[target], with out_valid=1.
  - The instruction shown in the redirect cycle is wrong-path. The decoder and hazard logic squash it; fetch does not count it.
- Redirect and stall together: redirect wins. The stalled instruction is discarded and the target is fetched.
- Stall: pc_q is held and the memory re-reads the same word. out_instr, out_pc and out_valid are stable for every stalled cycle.
- fetch_count:
  - Increments by 1 on each edge where state==RUN && !stall && !redirect.
  - Wraps at 2^32.
- Reset mid-operation: asynchronous clear regardless of state. The next instruction delivered is RESET_PC after one BOOT cycle.

Decomposition:
- Package legv8_pkg holds:
  - fetch state enum {BOOT, RUN, HALT}.
  - PC_INC = 4.
  - HALT_INSN default.
  - INSN_W = 32.
- One natural sub-module: legv8_next_pc_mux, the combinational priority mux and the +4 incrementer. The state machine, PC register and counter stay in the top module.

Test Plan:
- Reset release, memory words 0..3 = distinct values → cycle 0 out_valid=0; cycles 1..4 out_pc=0,4,8,12 with the matching words; imem_addr=1,2,3,4 on those cycles.
- stall high for 3 cycles while out_pc=8 → out_pc=8 and the same instruction held for 3 cycles; fetch_count unchanged; then out_pc=12.
- redirect with redirect_pc=0x1B at out_pc=4 → next cycle out_pc=0x18, out_instr=mem[6], out_valid=1; fetch_count does not count the redirect cycle.
- redirect and stall together at out_pc=8, redirect_pc=0x28 → next cycle out_pc=0x28; stall ignored.
- mem[5]=32'hFFFF_FFFF with sequential fetch → when out_pc=20, halted=1 from the next cycle; out_valid=0; imem_addr held at 5 and pc_q frozen; redirect ignored.
- rst_n pulsed low mid-stream at out_pc=16 → outputs clear immediately without a clock; after release, one BOOT cycle then out_pc=0 and fetch_count=0.
